ex_muldiv_ctrl: RTL and testbench

Iterative RV32M multiply/divide sequencer attached to the EX stage. It accepts one M-extension operation at a time from the ID/EX latch. It runs a radix-2 shift-add multiply or restoring divide over 32 cycles on a private datapath, and holds the pipeline with a stall until the result is ready. The EX stage result mux selects its output in place of the ALU result when the instruction is an M-extension op.

---
 rtl/ex_muldiv_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the EX stage (radix-2, 32 iterations).
// Define EX_MULDIV_DIV_EN to build the restoring divider; otherwise divide ops complete as illegal.
module ex_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_i_start,
  input  logic [2:0]  md_i_funct3,
  input  logic [31:0] md_i_a,
  input  logic [31:0] md_i_b,
  input  logic        md_i_flush,
  output logic        md_o_stall,
  output logic        md_o_valid,
  output logic [31:0] md_o_result,
  output logic        md_o_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [2:0]  op_reg, op_next;
  logic        neg_q_reg, neg_q_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] mcand_reg, mcand_next;
  logic [31:0] result_reg, result_next;
  logic        illegal_reg, illegal_next;
`ifdef EX_MULDIV_DIV_EN
  logic        neg_r_reg, neg_r_next;
`endif

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (md_i_funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_signed & md_i_a[31];
  assign b_neg = b_signed & md_i_b[31];
  assign a_mag = a_neg ? (~md_i_a + 32'd1) : md_i_a;
  assign b_mag = b_neg ? (~md_i_b + 32'd1) : md_i_b;

  // Multiply step: conditional add into the upper half, then shift {carry, acc, lo} right.
  logic [32:0] mul_sum;
  logic [31:0] mul_acc, mul_lo;
  assign mul_sum = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : 33'd0);
  assign mul_acc = mul_sum[32:1];
  assign mul_lo  = {mul_sum[0], lo_reg[31:1]};

  logic [31:0] iter_acc, iter_lo;
  logic [63:0] prod_raw, prod_fix;
  logic [31:0] mul_result, calc_result;
  logic        special;
  logic [31:0] special_result;
  logic        special_illegal;

  assign prod_raw   = {iter_acc, iter_lo};
  assign prod_fix   = neg_q_reg ? (~prod_raw + 64'd1) : prod_raw;
  assign mul_result = (op_reg == 3'b000) ? prod_fix[31:0] : prod_fix[63:32];

`ifdef EX_MULDIV_DIV_EN
  // Restoring divide step on {rem, quot}; the shifted remainder needs 33 bits for DIVU.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_acc, div_lo, quot_fix, rem_fix;
  logic        div_by_zero, div_ovf;

  assign div_shift = {acc_reg, lo_reg[31]};
  assign div_ge    = (div_shift >= {1'b0, mcand_reg});
  assign div_acc   = div_ge ? (div_shift[31:0] - mcand_reg) : div_shift[31:0];
  assign div_lo    = {lo_reg[30:0], div_ge};
  assign iter_acc  = op_reg[2] ? div_acc : mul_acc;
  assign iter_lo   = op_reg[2] ? div_lo  : mul_lo;

  assign quot_fix    = neg_q_reg ? (~iter_lo + 32'd1) : iter_lo;
  assign rem_fix     = neg_r_reg ? (~iter_acc + 32'd1) : iter_acc;
  assign calc_result = op_reg[2] ? (op_reg[1] ? rem_fix : quot_fix) : mul_result;

  assign div_by_zero = md_i_funct3[2] & (md_i_b == 32'd0);
  assign div_ovf     = md_i_funct3[2] & ~md_i_funct3[0] &
                       (md_i_a == 32'h8000_0000) & (md_i_b == 32'hFFFF_FFFF);
  assign special         = div_by_zero | div_ovf;
  assign special_result  = div_by_zero ? (md_i_funct3[1] ? md_i_a : 32'hFFFF_FFFF)
                                       : (md_i_funct3[1] ? 32'd0  : 32'h8000_0000);
  assign special_illegal = 1'b0;
`else
  assign iter_acc        = mul_acc;
  assign iter_lo         = mul_lo;
  assign calc_result     = mul_result;
  assign special         = md_i_funct3[2];
  assign special_result  = 32'd0;
  assign special_illegal = md_i_funct3[2];
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    neg_q_next   = neg_q_reg;
    acc_next     = acc_reg;
    lo_next      = lo_reg;
    mcand_next   = mcand_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
`ifdef EX_MULDIV_DIV_EN
    neg_r_next   = neg_r_reg;
`endif
    if (md_i_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (md_i_start) begin
            op_next      = md_i_funct3;
            neg_q_next   = a_neg ^ b_neg;
`ifdef EX_MULDIV_DIV_EN
            neg_r_next   = a_neg;
`endif
            acc_next     = 32'd0;
            cnt_next     = 5'd0;
            illegal_next = special_illegal;
            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
            if (md_i_funct3[2]) begin
              lo_next    = a_mag;
              mcand_next = b_mag;
            end else begin
              lo_next    = b_mag;
              mcand_next = a_mag;
            end
            if (special) begin
              result_next = special_result;
              state_next  = DONE;
            end else begin
              state_next  = CALC;
            end
          end
        end
        CALC: begin
          acc_next = iter_acc;
          lo_next  = iter_lo;
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            result_next = calc_result;
            state_next  = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 5'd0;
      op_reg      <= 3'd0;
      neg_q_reg   <= 1'b0;
      acc_reg     <= 32'd0;
      lo_reg      <= 32'd0;
      mcand_reg   <= 32'd0;
      result_reg  <= 32'd0;
      illegal_reg <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
      neg_r_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      neg_q_reg   <= neg_q_next;
      acc_reg     <= acc_next;
      lo_reg      <= lo_next;
      mcand_reg   <= mcand_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
`ifdef EX_MULDIV_DIV_EN
      neg_r_reg   <= neg_r_next;
`endif
    end
  end

  assign md_o_stall   = ((state_reg == IDLE) & md_i_start & ~md_i_flush) | (state_reg == CALC);
  assign md_o_valid   = (state_reg == DONE);
  assign md_o_illegal = (state_reg == DONE) & illegal_reg;
  assign md_o_result  = result_reg;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed literal cases plus randomized ops
// compared every cycle against an arithmetic reference with a cycle-count latency model.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        md_i_start = 1'b0;
  logic [2:0]  md_i_funct3 = 3'd0;
  logic [31:0] md_i_a = 32'd0;
  logic [31:0] md_i_b = 32'd0;
  logic        md_i_flush = 1'b0;
  logic        md_o_stall, md_o_valid, md_o_illegal;
  logic [31:0] md_o_result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int n_valid  = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .md_i_start   (md_i_start),
    .md_i_funct3  (md_i_funct3),
    .md_i_a       (md_i_a),
    .md_i_b       (md_i_b),
    .md_i_flush   (md_i_flush),
    .md_o_stall   (md_o_stall),
    .md_o_valid   (md_o_valid),
    .md_o_result  (md_o_result),
    .md_o_illegal (md_o_illegal)
  );

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %08h expected %08h", name, $time, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0b expected %0b", name, $time, got, exp);
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_val(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f)
      3'b000: begin p = sa * sb;           return p[31:0];  end
      3'b001: begin p = sa * sb;           return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub;           return p[63:32]; end
`ifdef EX_MULDIV_DIV_EN
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic logic ref_short(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MULDIV_DIV_EN
    return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    if (a == b) return f[2];
    return f[2];
`endif
  endfunction

  function automatic logic ref_illegal(input logic [2:0] f);
`ifdef EX_MULDIV_DIV_EN
    return 1'b0 & f[2];
`else
    return f[2];
`endif
  endfunction

  function automatic logic [31:0] dv(input logic [31:0] x);
`ifdef EX_MULDIV_DIV_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  function automatic int dlat(input int n);
`ifdef EX_MULDIV_DIV_EN
    return n;
`else
    return 2 + 0 * n;
`endif
  endfunction

  // Behavioural model: accepted op is outstanding for 32 more edges (or none if short), then one valid cycle.
  logic        m_busy, m_done, m_ill;
  int          m_left;
  logic [31:0] m_res, m_pend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_ill <= 1'b0;
      m_left <= 0;    m_res  <= 32'd0; m_pend <= 32'd0;
    end else if (md_i_flush) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend; m_ill <= 1'b0;
      end
      m_left <= m_left - 1;
    end else if (md_i_start) begin
      if (ref_short(md_i_funct3, md_i_a, md_i_b)) begin
        m_done <= 1'b1;
        m_res  <= ref_val(md_i_funct3, md_i_a, md_i_b);
        m_ill  <= ref_illegal(md_i_funct3);
      end else begin
        m_busy <= 1'b1;
        m_left <= 32;
        m_pend <= ref_val(md_i_funct3, md_i_a, md_i_b);
      end
    end
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    check1("stall", md_o_stall, m_busy | (!m_busy && !m_done && md_i_start && !md_i_flush));
    check1("valid", md_o_valid, m_done);
    check1("illegal", md_o_illegal, m_done & m_ill);
    check32("result", md_o_result, m_res);
    if (md_o_valid) begin
      n_valid   <= n_valid + 1;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc_cnt;
    end
  end

  // Called and returns #1 after a rising edge; holds start until the op leaves EX.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input logic lit_chk, input int lat,
                        input int flush_at, input string name);
    int          cyc;
    logic        seen, flushed, ill;
    logic [31:0] res;
    cyc = 0; seen = 1'b0; flushed = 1'b0; ill = 1'b0; res = 32'd0;
    md_i_start = 1'b1; md_i_funct3 = f; md_i_a = a; md_i_b = b; md_i_flush = 1'b0;
    while (!seen && !flushed && cyc < 100) begin
      if (cyc == flush_at) md_i_flush = 1'b1;
      @(negedge clk);
      if (md_o_valid) begin
        seen = 1'b1; res = md_o_result; ill = md_o_illegal;
      end
      @(posedge clk); #1;
      if (md_i_flush) flushed = 1'b1;
      cyc++;
    end
    md_i_start = 1'b0;
    md_i_flush = 1'b0;
    check1({name, "_done"}, seen | flushed, 1'b1);
    $display("op %s f3=%0d a=%08h b=%08h result=%08h illegal=%0b cycles=%0d flushed=%0b",
             name, f, a, b, res, ill, cyc, flushed);
    if (seen && !flushed) begin
      check32({name, "_latency"}, 32'(cyc), 32'(lat));
      check1({name, "_illegal"}, ill, ref_illegal(f));
      if (lit_chk) check32({name, "_lit"}, res, lit);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int          v0;
    logic [2:0]  f;
    logic [31:0] a, b;
    int          fa;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check1("reset_stall", md_o_stall, 1'b0);
    check1("reset_valid", md_o_valid, 1'b0);
    check32("reset_result", md_o_result, 32'd0);
    check1("reset_illegal", md_o_illegal, 1'b0);
    @(posedge clk); #1;

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA, 1'b1, 34, -1, "mul_m2x3");
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 1'b1, 34, -1, "mulh_m2x3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 34, -1, "mulhu_max");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 34, -1, "mulh_m1xm1");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 34, -1, "mulhsu_m1");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 34, -1, "mulh_min2");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,   dv(32'hFFFF_FFFD), 1'b1, dlat(34), -1, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,   dv(32'hFFFF_FFFF), 1'b1, dlat(34), -1, "rem_m7_2");
    run_op(3'b101, 32'd100,       32'd7,   dv(32'd14),        1'b1, dlat(34), -1, "divu_100_7");
    run_op(3'b101, 32'd5,         32'd0,   dv(32'hFFFF_FFFF), 1'b1, 2,        -1, "divu_by0");
    run_op(3'b110, 32'd5,         32'd0,   dv(32'd5),         1'b1, 2,        -1, "rem_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), 1'b1, 2,  -1, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0),   1'b1, 2,        -1, "rem_ovf");

    // Back-to-back: second op presented on the edge ending the first op's DONE cycle.
    run_op(3'b000, 32'd6,  32'd7, 32'd42,    1'b1, 34,       -1, "b2b_mul");
    run_op(3'b101, 32'd42, 32'd5, dv(32'd8), 1'b1, dlat(34), -1, "b2b_divu");
    check32("b2b_gap", 32'(last_vcyc - prev_vcyc), 32'(dlat(34)));

    v0 = n_valid;
`ifdef EX_MULDIV_DIV_EN
    run_op(3'b100, 32'd1000, 32'd7, 32'd0, 1'b0, 34, 11, "flush_div");
`else
    run_op(3'b001, 32'd1000, 32'd7, 32'd0, 1'b0, 34, 11, "flush_mulh");
`endif
    repeat (3) @(posedge clk);
    #1;
    check32("flush_novalid", 32'(n_valid - v0), 32'd0);
    check32("flush_hold", md_o_result, dv(32'd8));
    run_op(3'b101, 32'd100, 32'd7, dv(32'd14), 1'b1, dlat(34), -1, "after_flush");

    // Asynchronous reset in the middle of a multiply.
    md_i_funct3 = 3'b000; md_i_a = 32'd3; md_i_b = 32'd5; md_i_start = 1'b1;
    repeat (12) @(posedge clk);
    #1 md_i_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check1("midrst_stall", md_o_stall, 1'b0);
    check1("midrst_valid", md_o_valid, 1'b0);
    check32("midrst_result", md_o_result, 32'd0);
    check1("midrst_illegal", md_o_illegal, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    v0 = n_valid;
    repeat (40) @(posedge clk);
    #1;
    check32("midrst_novalid", 32'(n_valid - v0), 32'd0);
    run_op(3'b000, 32'd6, 32'd7, 32'd42, 1'b1, 34, -1, "after_reset");

    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      fa = -1;
      if ($urandom_range(0, 9) == 0) fa = f[2] ? 0 : $urandom_range(0, 32);
      run_op(f, a, b, 32'd0, 1'b0, ref_short(f, a, b) ? 2 : 34, fa, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
